// File: rtl/vram_arbiter.sv
`default_nettype none
// ==========================================================================
// vram_arbiter : single-port VRAM arbiter for display fetch, CPU and clear
// Revision     : 1.0
// ==========================================================================
module vram_arbiter #(
   parameter int DEPTH        = 601,
   parameter int AW           = 10,
   parameter int MAX_CPU_WAIT = 4
) (
   input  logic          CLK,
   input  logic          RESET_N,
   input  logic          DISP_REQ,
   input  logic [AW-1:0] DISP_ADDR,
   output logic          DISP_READY,
   output logic          DISP_VALID,
   output logic [31:0]   DISP_DATA,
   input  logic          AVL_CS,
   input  logic          AVL_READ,
   input  logic          AVL_WRITE,
   input  logic [AW-1:0] AVL_ADDR,
   input  logic [31:0]   AVL_WRITEDATA,
   output logic          AVL_WAITREQUEST,
   output logic          AVL_READDATAVALID,
   output logic [31:0]   AVL_READDATA,
   input  logic          CLEAR_START,
   output logic          CLEAR_BUSY,
   output logic          VRAM_CS,
   output logic          VRAM_READ,
   output logic          VRAM_WRITE,
   output logic [AW-1:0] VRAM_ADDR,
   output logic [31:0]   VRAM_DIN,
   input  logic [31:0]   VRAM_DOUT
);

   localparam int             WCW       = $clog2(MAX_CPU_WAIT + 1);
   localparam logic [0:0]     ST_IDLE   = 1'b0;
   localparam logic [0:0]     ST_CLEAR  = 1'b1;
   localparam logic [AW:0]    DEPTH_W   = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0]  ADDR_ONE  = AW'(1);
   localparam logic [WCW-1:0] WAIT_MAX  = WCW'(MAX_CPU_WAIT);
   localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);

   logic [0:0]     state_q, state_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic [AW-1:0]  clr_addr_q, clr_addr_d;
   logic           disp_valid_q, disp_valid_d;
   logic           cpu_valid_q, cpu_valid_d;
   logic           rd_oor_q, rd_oor_d;

   logic cpu_pend, cpu_rd, disp_in, cpu_in;
   logic grant_disp, grant_cpu, clr_wr;

   assign cpu_pend = AVL_CS & (AVL_READ | AVL_WRITE);
   assign cpu_rd   = AVL_READ;
   assign disp_in  = {1'b0, DISP_ADDR} < DEPTH_W;
   assign cpu_in   = {1'b0, AVL_ADDR} < DEPTH_W;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      clr_addr_d = clr_addr_q;
      grant_disp = 1'b0;
      grant_cpu  = 1'b0;
      clr_wr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cpu_pend && (wait_cnt_q == WAIT_MAX)) grant_cpu  = 1'b1;
            else if (DISP_REQ)                        grant_disp = 1'b1;
            else if (cpu_pend)                        grant_cpu  = 1'b1;
            // a pending CPU access that was not granted lost to display
            if (grant_cpu || !cpu_pend)          wait_cnt_d = '0;
            else if (wait_cnt_q != WAIT_MAX)     wait_cnt_d = wait_cnt_q + WAIT_ONE;
            if (CLEAR_START) begin
               state_d    = ST_CLEAR;
               clr_addr_d = '0;
            end
         end
         ST_CLEAR: begin
            if (DISP_REQ) begin
               grant_disp = 1'b1;
            end else begin
               clr_wr = 1'b1;
               if (clr_addr_q == LAST_ADDR) begin
                  state_d    = ST_IDLE;
                  clr_addr_d = '0;
               end else begin
                  clr_addr_d = clr_addr_q + ADDR_ONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      VRAM_CS    = 1'b0;
      VRAM_READ  = 1'b0;
      VRAM_WRITE = 1'b0;
      VRAM_ADDR  = '0;
      VRAM_DIN   = '0;
      if (grant_disp) begin
         VRAM_ADDR = DISP_ADDR;
         VRAM_CS   = disp_in;
         VRAM_READ = disp_in;
      end else if (grant_cpu) begin
         VRAM_ADDR = AVL_ADDR;
         if (cpu_in) begin
            VRAM_CS    = 1'b1;
            VRAM_READ  = cpu_rd;
            VRAM_WRITE = ~cpu_rd;
            VRAM_DIN   = cpu_rd ? 32'h0 : AVL_WRITEDATA;
         end
      end else if (clr_wr) begin
         VRAM_CS    = 1'b1;
         VRAM_WRITE = 1'b1;
         VRAM_ADDR  = clr_addr_q;
      end
   end

   always_comb begin
      disp_valid_d = grant_disp;
      cpu_valid_d  = grant_cpu & cpu_rd;
      rd_oor_d     = grant_disp ? ~disp_in : ~cpu_in;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= '0;
         clr_addr_q   <= '0;
         disp_valid_q <= 1'b0;
         cpu_valid_q  <= 1'b0;
         rd_oor_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         clr_addr_q   <= clr_addr_d;
         disp_valid_q <= disp_valid_d;
         cpu_valid_q  <= cpu_valid_d;
         rd_oor_q     <= rd_oor_d;
      end
   end

   assign DISP_READY        = grant_disp;
   assign AVL_WAITREQUEST   = cpu_pend & ~grant_cpu;
   assign CLEAR_BUSY        = (state_q == ST_CLEAR);
   assign DISP_VALID        = disp_valid_q;
   assign AVL_READDATAVALID = cpu_valid_q;
   // out-of-range reads never strobed the VRAM, so their data is forced to zero
   assign DISP_DATA         = (disp_valid_q && !rd_oor_q) ? VRAM_DOUT : 32'h0;
   assign AVL_READDATA      = (cpu_valid_q  && !rd_oor_q) ? VRAM_DOUT : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_vram_arbiter : randomized + directed bench with transaction-level model
// Revision        : 1.0
// ==========================================================================
module tb_vram_arbiter;

   localparam int DEPTH    = 601;
   localparam int AW       = 10;
   localparam int MAX_WAIT = 4;

   logic          CLK, RESET_N;
   logic          DISP_REQ, DISP_READY, DISP_VALID;
   logic [AW-1:0] DISP_ADDR;
   logic [31:0]   DISP_DATA;
   logic          AVL_CS, AVL_READ, AVL_WRITE, AVL_WAITREQUEST, AVL_READDATAVALID;
   logic [AW-1:0] AVL_ADDR;
   logic [31:0]   AVL_WRITEDATA, AVL_READDATA;
   logic          CLEAR_START, CLEAR_BUSY;
   logic          VRAM_CS, VRAM_READ, VRAM_WRITE;
   logic [AW-1:0] VRAM_ADDR;
   logic [31:0]   VRAM_DIN, VRAM_DOUT;

   vram_arbiter #(.DEPTH(DEPTH), .AW(AW), .MAX_CPU_WAIT(MAX_WAIT)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_READY(DISP_READY),
      .DISP_VALID(DISP_VALID), .DISP_DATA(DISP_DATA),
      .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
      .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
      .AVL_WAITREQUEST(AVL_WAITREQUEST), .AVL_READDATAVALID(AVL_READDATAVALID),
      .AVL_READDATA(AVL_READDATA),
      .CLEAR_START(CLEAR_START), .CLEAR_BUSY(CLEAR_BUSY),
      .VRAM_CS(VRAM_CS), .VRAM_READ(VRAM_READ), .VRAM_WRITE(VRAM_WRITE),
      .VRAM_ADDR(VRAM_ADDR), .VRAM_DIN(VRAM_DIN), .VRAM_DOUT(VRAM_DOUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // VRAM with one-cycle registered read
   logic [31:0] vmem [0:1023];
   always @(posedge CLK) begin
      if (VRAM_CS && VRAM_WRITE) vmem[VRAM_ADDR] <= VRAM_DIN;
      if (VRAM_CS && VRAM_READ)  VRAM_DOUT <= vmem[VRAM_ADDR];
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // reference model: expected memory contents and arbitration bookkeeping
   logic [31:0] shadow [0:1023];
   int          m_wait;
   bit          m_clearing;
   int          m_clr;
   bit          exp_dv, exp_cv;
   logic [31:0] exp_dd, exp_cd;

   task automatic model_reset();
      m_wait = 0; m_clearing = 0; m_clr = 0;
      exp_dv = 0; exp_cv = 0; exp_dd = 0; exp_cd = 0;
   endtask

   task automatic zero_inputs();
      DISP_REQ = 0; DISP_ADDR = 0; AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0;
      AVL_ADDR = 0; AVL_WRITEDATA = 0; CLEAR_START = 0;
   endtask

   task automatic cycle(input logic dreq, input int daddr, input logic cs, input logic rd,
                        input logic wr, input int caddr, input logic [31:0] wd,
                        input logic cstart, output logic gd, output logic gc);
      logic pend, gclr, ew, er;
      int ea;
      logic [31:0] edin;
      @(negedge CLK);
      check("clear_busy", 32'(CLEAR_BUSY), 32'(m_clearing));
      check("disp_valid", 32'(DISP_VALID), 32'(exp_dv));
      if (exp_dv) check("disp_data", DISP_DATA, exp_dd);
      check("cpu_valid", 32'(AVL_READDATAVALID), 32'(exp_cv));
      if (exp_cv) check("cpu_data", AVL_READDATA, exp_cd);
      DISP_REQ = dreq; DISP_ADDR = AW'(daddr);
      AVL_CS = cs; AVL_READ = rd; AVL_WRITE = wr; AVL_ADDR = AW'(caddr);
      AVL_WRITEDATA = wd; CLEAR_START = cstart;
      #1;
      pend = cs & (rd | wr);
      gd = 0; gc = 0; gclr = 0;
      if (m_clearing) begin
         if (dreq) gd = 1; else gclr = 1;
      end else if (pend && m_wait >= MAX_WAIT) gc = 1;
      else if (dreq) gd = 1;
      else if (pend) gc = 1;
      ew = 0; er = 0; ea = 0; edin = 0;
      if (gd && daddr < DEPTH) begin er = 1; ea = daddr; end
      if (gc && caddr < DEPTH) begin
         ea = caddr;
         if (rd) er = 1; else begin ew = 1; edin = wd; end
      end
      if (gclr) begin ew = 1; ea = m_clr; edin = 0; end
      check("disp_ready", 32'(DISP_READY), 32'(gd));
      check("waitrequest", 32'(AVL_WAITREQUEST), 32'(pend & ~gc));
      check("vram_read", 32'(VRAM_READ), 32'(er));
      check("vram_write", 32'(VRAM_WRITE), 32'(ew));
      check("vram_cs", 32'(VRAM_CS), 32'(er | ew));
      if (er | ew) check("vram_addr", 32'(VRAM_ADDR), 32'(ea));
      if (ew) check("vram_din", VRAM_DIN, edin);
      exp_dv = gd;
      exp_dd = (daddr < DEPTH) ? shadow[daddr] : 32'h0;
      exp_cv = gc & rd;
      exp_cd = (caddr < DEPTH) ? shadow[caddr] : 32'h0;
      if (ew) shadow[ea] = edin;
      if (!m_clearing) begin
         if (gc || !pend) m_wait = 0;
         else if (m_wait < MAX_WAIT) m_wait++;
      end
      if (m_clearing) begin
         if (gclr) begin
            if (m_clr == DEPTH - 1) begin m_clearing = 0; m_clr = 0; end
            else m_clr++;
         end
      end else if (cstart) begin
         m_clearing = 1; m_clr = 0;
      end
   endtask

   function automatic int rand_addr();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return int'($urandom_range(DEPTH, 1023));
      if (r < 5)  return int'($urandom_range(0, 15));
      return int'($urandom_range(0, DEPTH - 1));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic gd, gc, dq, q_cs, q_rd, q_wr, cst;
      int da, ca, n, waits, kind;
      logic [31:0] cwd;

      RESET_N = 0;
      VRAM_DOUT = 0;
      zero_inputs();
      model_reset();
      for (int i = 0; i < 1024; i++) begin
         vmem[i]   = $urandom;
         shadow[i] = vmem[i];
      end

      // reset state
      #12;
      check("rst_disp_ready", 32'(DISP_READY), 0);
      check("rst_disp_valid", 32'(DISP_VALID), 0);
      check("rst_disp_data", DISP_DATA, 0);
      check("rst_waitreq", 32'(AVL_WAITREQUEST), 0);
      check("rst_cpu_valid", 32'(AVL_READDATAVALID), 0);
      check("rst_cpu_data", AVL_READDATA, 0);
      check("rst_busy", 32'(CLEAR_BUSY), 0);
      check("rst_strobes", 32'({VRAM_CS, VRAM_READ, VRAM_WRITE}), 0);
      check("rst_vaddr", 32'(VRAM_ADDR), 0);
      check("rst_vdin", VRAM_DIN, 0);
      @(negedge CLK);
      RESET_N = 1;
      for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, gd, gc);

      // CPU write then read back
      cycle(0, 0, 1, 0, 1, 5, 32'h600DCAFE, 0, gd, gc);
      check("t2_write_nowait", 32'(gc), 1);
      cycle(0, 0, 1, 1, 0, 5, 0, 0, gd, gc);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, gd, gc);
      check("t2_readback", AVL_READDATA, 32'h600DCAFE);

      // display held high starves CPU for exactly MAX_WAIT cycles
      waits = 0;
      for (int k = 0; k < 10; k++) begin
         cycle(1, k, 1, 1, 0, 7, 0, 0, gd, gc);
         if (gc) begin
            check("t3_ready_low", 32'(DISP_READY), 0);
            break;
         end
         waits++;
      end
      check("t3_wait", waits, MAX_WAIT);

      // simultaneous requests, display first
      cycle(1, 0, 1, 1, 0, 1, 0, 0, gd, gc);
      check("t4_first", 32'({gd, gc}), 32'h2);
      cycle(0, 0, 1, 1, 0, 1, 0, 0, gd, gc);
      check("t4_second", 32'({gd, gc}), 32'h1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, gd, gc);

      // out-of-range access
      cycle(0, 0, 1, 0, 1, DEPTH, 32'hFFFFFFFF, 0, gd, gc);
      check("t5_oor_write_grant", 32'(gc), 1);
      cycle(0, 0, 1, 1, 0, DEPTH, 0, 0, gd, gc);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, gd, gc);
      check("t5_oor_read_data", AVL_READDATA, 0);

      // clear sweep without display traffic, then read every word back
      cycle(0, 0, 0, 0, 0, 0, 0, 1, gd, gc);
      n = 0;
      for (int k = 0; k < 2000; k++) begin
         cycle(0, 0, 0, 0, 0, 0, 0, 0, gd, gc);
         if (CLEAR_BUSY) n++; else break;
      end
      check("t6_sweep_len", n, DEPTH);
      for (int a = 0; a < DEPTH; a++) cycle(0, 0, 1, 1, 0, a, 0, 0, gd, gc);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, gd, gc);

      // sweep with display every other cycle
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 1, i, $urandom, 0, gd, gc);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, gd, gc);
      n = 0;
      for (int k = 0; k < 3000; k++) begin
         cycle(k % 2 == 0, rand_addr(), 0, 0, 0, 0, 0, 0, gd, gc);
         if (CLEAR_BUSY) n++; else break;
      end
      check("t6_sweep_len_disp", n, 2 * DEPTH);

      // restore nonzero contents, then abort a sweep with reset
      for (int i = 0; i < 200; i++) cycle(0, 0, 1, 0, 1, i * 3, $urandom, 0, gd, gc);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, gd, gc);
      for (int k = 0; k < 100; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, gd, gc);
      @(posedge CLK);
      #2;
      zero_inputs();
      RESET_N = 0;
      #1;
      check("t6_abort_busy", 32'(CLEAR_BUSY), 0);
      check("t6_abort_valid", 32'({DISP_VALID, AVL_READDATAVALID}), 0);
      model_reset();
      @(negedge CLK);
      @(negedge CLK);
      RESET_N = 1;

      // randomized traffic
      dq = 0; q_cs = 0; q_rd = 0; q_wr = 0; da = 0; ca = 0; cwd = 0;
      for (int i = 0; i < 4000; i++) begin
         if (!dq && $urandom_range(0, 2) != 0) begin dq = 1; da = rand_addr(); end
         if (!q_cs && $urandom_range(0, 2) != 0) begin
            kind = int'($urandom_range(0, 3));
            q_cs = 1;
            q_rd = (kind != 0);
            q_wr = (kind == 0) || (kind == 3);
            ca   = rand_addr();
            cwd  = $urandom;
         end
         cst = ($urandom_range(0, 999) == 0);
         cycle(dq, da, q_cs, q_rd, q_wr, ca, cwd, cst, gd, gc);
         if (gd) dq = 0;
         if (gc) begin q_cs = 0; q_rd = 0; q_wr = 0; end
      end
      cycle(0, 0, 0, 0, 0, 0, 0, 0, gd, gc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
